// File: rtl/election_tally_pkg.sv
// Shared types for the election tally engine: FSM state encoding and decision-mode constants.
package election_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int MODE_ABSOLUTE = 0;
  localparam int MODE_RELATIVE = 1;

endpackage

// File: rtl/election_tally_popcount.sv
// Combinational population count of a W-bit vector.
module popcount #(
  parameter int W  = 7,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/election_tally.sv
// Multi-cycle yes/no ballot collector and tally with absolute or relative majority verdict.
// Optional collection-window timeout is built when VOTE_TIMEOUT_EN is defined.
module election_tally
  import election_pkg::*;
#(
  parameter int N_VOTERS       = 7,
  parameter int MODE           = MODE_ABSOLUTE,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = $clog2(N_VOTERS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N_VOTERS-1:0] vote_valid,
  input  logic [N_VOTERS-1:0] vote_yes,
  output logic                busy,
  output logic                result_valid,
  output logic                result,
  output logic                tie,
  output logic                timed_out,
  output logic [CNT_W-1:0]    yes_count,
  output logic [CNT_W-1:0]    no_count,
  output state_t              state
);

  logic [N_VOTERS-1:0] voted_mask;
  logic [CNT_W-1:0]    yes_run;
  logic [CNT_W-1:0]    no_run;

  logic [N_VOTERS-1:0] new_votes;
  logic [N_VOTERS-1:0] new_yes;
  logic [N_VOTERS-1:0] new_no;
  logic [N_VOTERS-1:0] mask_next;
  logic [CNT_W-1:0]    yes_new;
  logic [CNT_W-1:0]    no_new;
  logic [CNT_W-1:0]    yes_next;
  logic [CNT_W-1:0]    no_next;
  logic                all_voted;
  logic                expire;
  logic                verdict;

  // Only first ballots count; repeats from a voter already in the mask are dropped.
  assign new_votes = vote_valid & ~voted_mask;
  assign new_yes   = new_votes & vote_yes;
  assign new_no    = new_votes & ~vote_yes;
  assign mask_next = voted_mask | new_votes;
  assign yes_next  = yes_run + yes_new;
  assign no_next   = no_run + no_new;
  assign all_voted = &mask_next;

  popcount #(.W(N_VOTERS), .CW(CNT_W)) u_pc_yes (.bits(new_yes), .count(yes_new));
  popcount #(.W(N_VOTERS), .CW(CNT_W)) u_pc_no  (.bits(new_no),  .count(no_new));

  always_comb begin
    if (MODE == MODE_RELATIVE) verdict = yes_next > no_next;
    else                       verdict = yes_next > CNT_W'(N_VOTERS / 2);
  end

`ifdef VOTE_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_cnt;

  assign expire = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Completion in the expiry cycle wins, so timed_out is only set when the mask is still short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt   <= '0;
      timed_out <= 1'b0;
    end else if (state == IDLE && start) begin
      tmo_cnt <= '0;
    end else if (state == COLLECT) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (all_voted || expire) timed_out <= expire && !all_voted;
    end
  end
`else
  assign expire    = 1'b0;
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      voted_mask   <= '0;
      yes_run      <= '0;
      no_run       <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= 1'b0;
      tie          <= 1'b0;
      yes_count    <= '0;
      no_count     <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= COLLECT;
            busy       <= 1'b1;
            voted_mask <= '0;
            yes_run    <= '0;
            no_run     <= '0;
          end
        end
        COLLECT: begin
          voted_mask <= mask_next;
          yes_run    <= yes_next;
          no_run     <= no_next;
          if (all_voted || expire) begin
            state        <= DONE;
            result_valid <= 1'b1;
            yes_count    <= yes_next;
            no_count     <= no_next;
            result       <= verdict;
            tie          <= (yes_next == no_next);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_election_tally.sv
// Scoreboard bench: an absolute-majority instance (N=7) and a relative-majority instance (N=6).
module tb_election_tally;
  import election_pkg::*;

  localparam int W = 9;  // {result, tie, timed_out, yes[2:0], no[2:0]}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_start = 1'b0;
  logic [6:0] a_valid = '0;
  logic [6:0] a_yes = '0;
  logic       a_busy, a_rv, a_result, a_tie, a_to;
  logic [2:0] a_yc, a_nc;
  state_t     a_state;

  logic       r_start = 1'b0;
  logic [5:0] r_valid = '0;
  logic [5:0] r_yes = '0;
  logic       r_busy, r_rv, r_result, r_tie, r_to;
  logic [2:0] r_yc, r_nc;
  state_t     r_state;

  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_r_q[$];
  int tests = 0;
  int fails = 0;

  election_tally #(.N_VOTERS(7), .MODE(MODE_ABSOLUTE), .TIMEOUT_CYCLES(4)) u_abs (
    .clk(clk), .rst_n(rst_n), .start(a_start), .vote_valid(a_valid), .vote_yes(a_yes),
    .busy(a_busy), .result_valid(a_rv), .result(a_result), .tie(a_tie), .timed_out(a_to),
    .yes_count(a_yc), .no_count(a_nc), .state(a_state)
  );

  election_tally #(.N_VOTERS(6), .MODE(MODE_RELATIVE), .TIMEOUT_CYCLES(4)) u_rel (
    .clk(clk), .rst_n(rst_n), .start(r_start), .vote_valid(r_valid), .vote_yes(r_yes),
    .busy(r_busy), .result_valid(r_rv), .result(r_result), .tie(r_tie), .timed_out(r_to),
    .yes_count(r_yc), .no_count(r_nc), .state(r_state)
  );

  function automatic logic [W-1:0] pk(input logic r, input logic t, input logic to,
                                      input logic [2:0] y, input logic [2:0] n);
    return {r, t, to, y, n};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic s, input logic [6:0] v, input logic [6:0] y);
    a_start = s; a_valid = v; a_yes = y;
    tick();
  endtask

  task automatic drive_r(input logic s, input logic [5:0] v, input logic [5:0] y);
    r_start = s; r_valid = v; r_yes = y;
    tick();
  endtask

  // Monitor: pops an expectation on every result_valid and checks the pulse is one cycle wide.
  logic a_prev = 1'b0;
  logic r_prev = 1'b0;
  always @(negedge clk) begin
    if (a_rv) begin
      if (a_prev) check("abs_rv_width", 32'(a_prev), 32'd0);
      if (exp_a_q.size() == 0) check("abs_unexpected_done", 32'd1, 32'd0);
      else check("abs_tally", 32'({a_result, a_tie, a_to, a_yc, a_nc}), 32'(exp_a_q.pop_front()));
    end
    if (r_rv) begin
      if (r_prev) check("rel_rv_width", 32'(r_prev), 32'd0);
      if (exp_r_q.size() == 0) check("rel_unexpected_done", 32'd1, 32'd0);
      else check("rel_tally", 32'({r_result, r_tie, r_to, r_yc, r_nc}), 32'(exp_r_q.pop_front()));
    end
    a_prev <= a_rv;
    r_prev <= r_rv;
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_abs_outputs", 32'({a_busy, a_rv, a_result, a_tie, a_to, a_yc, a_nc}), 32'd0);
    check("rst_abs_state", 32'(a_state), 32'(IDLE));
    check("rst_rel_outputs", 32'({r_busy, r_rv, r_result, r_tie, r_to, r_yc, r_nc}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single-batch ballots: 4 yes, 3 no.
    drive_a(1'b1, 7'h00, 7'h00);
    check("abs_busy_after_start", 32'(a_busy), 32'd1);
    exp_a_q.push_back(pk(1'b1, 1'b0, 1'b0, 3'd4, 3'd3));
    drive_a(1'b0, 7'h7F, 7'h0F);
    check("abs_latency_rv", 32'(a_rv), 32'd1);
    drive_a(1'b0, 7'h00, 7'h00);
    check("abs_busy_after_done", 32'(a_busy), 32'd0);

    // Reset mid-round aborts without a result.
    drive_a(1'b1, 7'h00, 7'h00);
    drive_a(1'b0, 7'h07, 7'h07);
    a_valid = '0; a_yes = '0;
    rst_n = 1'b0;
    #2;
    check("midrst_outputs", 32'({a_busy, a_rv, a_result, a_tie, a_to, a_yc, a_nc}), 32'd0);
    check("midrst_state", 32'(a_state), 32'(IDLE));
    tick();
    rst_n = 1'b1;
    tick();

    // Round after reset tallies from zero: all no.
    drive_a(1'b1, 7'h00, 7'h00);
    exp_a_q.push_back(pk(1'b0, 1'b0, 1'b0, 3'd0, 3'd7));
    drive_a(1'b0, 7'h7F, 7'h00);
    drive_a(1'b0, 7'h00, 7'h00);

    // Spread over three cycles: 3 yes exactly at the N/2 boundary fails.
    drive_a(1'b1, 7'h00, 7'h00);
    exp_a_q.push_back(pk(1'b0, 1'b0, 1'b0, 3'd3, 3'd4));
    drive_a(1'b0, 7'h03, 7'h07);
    drive_a(1'b0, 7'h0C, 7'h07);
    check("spread_not_done_early", 32'(a_rv), 32'd0);
    drive_a(1'b0, 7'h70, 7'h07);
    check("spread_rv", 32'(a_rv), 32'd1);
    drive_a(1'b0, 7'h00, 7'h00);

    // Duplicate ballot with a changed value is ignored.
    drive_a(1'b1, 7'h00, 7'h00);
    exp_a_q.push_back(pk(1'b0, 1'b0, 1'b0, 3'd1, 3'd6));
    drive_a(1'b0, 7'h01, 7'h01);
    drive_a(1'b0, 7'h01, 7'h00);
    drive_a(1'b0, 7'h7E, 7'h00);
    drive_a(1'b0, 7'h00, 7'h00);

    // Unanimous yes.
    drive_a(1'b1, 7'h00, 7'h00);
    exp_a_q.push_back(pk(1'b1, 1'b0, 1'b0, 3'd7, 3'd0));
    drive_a(1'b0, 7'h7F, 7'h7F);
    drive_a(1'b0, 7'h00, 7'h00);

    // Relative mode: 3 yes / 3 no is a tie and fails.
    drive_r(1'b1, 6'h00, 6'h00);
    exp_r_q.push_back(pk(1'b0, 1'b1, 1'b0, 3'd3, 3'd3));
    drive_r(1'b0, 6'h3F, 6'h07);
    drive_r(1'b0, 6'h00, 6'h00);

    // start held through COLLECT is ignored; no extra round follows.
    drive_r(1'b1, 6'h00, 6'h00);
    exp_r_q.push_back(pk(1'b1, 1'b0, 1'b0, 3'd6, 3'd0));
    drive_r(1'b1, 6'h01, 6'h01);
    drive_r(1'b1, 6'h3E, 6'h3E);
    check("rel_start_ignored_done", 32'(r_rv), 32'd1);
    drive_r(1'b0, 6'h00, 6'h00);
    drive_r(1'b0, 6'h00, 6'h00);
    check("rel_no_extra_round", 32'(r_busy), 32'd0);

    // Relative mode: 2 yes / 4 no.
    drive_r(1'b1, 6'h00, 6'h00);
    exp_r_q.push_back(pk(1'b0, 1'b0, 1'b0, 3'd2, 3'd4));
    drive_r(1'b0, 6'h3F, 6'h03);
    drive_r(1'b0, 6'h00, 6'h00);

`ifdef VOTE_TIMEOUT_EN
    // Timeout: 2 yes, 1 no, others silent; closes after 4 COLLECT cycles.
    drive_a(1'b1, 7'h00, 7'h00);
    exp_a_q.push_back(pk(1'b0, 1'b0, 1'b1, 3'd2, 3'd1));
    drive_a(1'b0, 7'h07, 7'h03);
    n = 1;
    while (!a_rv && n < 10) begin
      drive_a(1'b0, 7'h00, 7'h00);
      n++;
    end
    check("abs_timeout_cycles", 32'(n), 32'd4);
    drive_a(1'b0, 7'h00, 7'h00);

    drive_r(1'b1, 6'h00, 6'h00);
    exp_r_q.push_back(pk(1'b1, 1'b0, 1'b1, 3'd2, 3'd1));
    drive_r(1'b0, 6'h07, 6'h03);
    n = 1;
    while (!r_rv && n < 10) begin
      drive_r(1'b0, 6'h00, 6'h00);
      n++;
    end
    check("rel_timeout_cycles", 32'(n), 32'd4);
    drive_r(1'b0, 6'h00, 6'h00);
`else
    n = 0;
`endif

    repeat (3) tick();
    check("abs_all_results_seen", 32'(exp_a_q.size()), 32'd0);
    check("rel_all_results_seen", 32'(exp_r_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
